// File: rtl/sumador_serie_ctrl.sv
// Serial N x 4-bit adder controller: drives one external 4-bit adder slice LS nibble first.
// Optional signed-overflow output enabled by defining SUMADOR_OVF_EN.
module sumador_serie_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
`ifdef SUMADOR_OVF_EN
    output logic                   ovf,
`endif
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout
);

    localparam int W  = 4*NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES-1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    w_acc_next;
    logic            r_carry;
    logic [KW-1:0]   r_k;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            w_accept;
    logic            w_last;
`ifdef SUMADOR_OVF_EN
    logic            r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_last     = (r_k == K_LAST);
        busy       = 1'b0;
        done       = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        w_acc_next = r_acc;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                add_a   = r_a[4*int'(r_k) +: 4];
                add_b   = r_b[4*int'(r_k) +: 4];
                add_cin = r_carry;
                w_acc_next[4*int'(r_k) +: 4] = add_s;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The final nibble is merged from the adder output directly, so sum is complete on the last RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SUMADOR_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_carry <= cin;
            r_k     <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= add_cout;
            r_k     <= w_last ? '0 : r_k + KW'(1);
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= add_cout;
`ifdef SUMADOR_OVF_EN
                r_ovf  <= (r_a[W-1] == r_b[W-1]) && (add_s[3] != r_a[W-1]);
`endif
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SUMADOR_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Directed bench for sumador_serie_ctrl (NIBBLES=4); the bench models the external 4-bit adder.
module tb_sumador_serie_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout;
    logic [15:0] sum;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;
`ifdef SUMADOR_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    sumador_serie_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
`ifdef SUMADOR_OVF_EN
        .ovf(ovf),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation; returns cycles from accept edge to done, RUN cycle count and add_cin per nibble.
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                         output int lat, output int nbusy, output logic [3:0] ctrace);
        a = ia; b = ib; cin = ic; start = 1'b1;
        cyc();
        start = 1'b0;
        lat = 1; nbusy = 0; ctrace = '0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) begin
                if (nbusy < 4) ctrace[nbusy] = add_cin;
                nbusy++;
            end
            cyc();
            lat++;
        end
    endtask

    task automatic test_reset();
        cyc();
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (sum !== 16'h0)   begin n_fail++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        n_checks++; if (cout !== 1'b0)   begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
        n_checks++; if ({add_a, add_b, add_cin} !== 9'h0)
            begin n_fail++; $display("FAIL reset_add got=%h exp=000", {add_a, add_b, add_cin}); end
        #3 rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        int lat, nb; logic [3:0] tr;
        do_op(16'h1234, 16'h4321, 1'b0, lat, nb, tr);
        n_checks++; if (lat !== 5)       begin n_fail++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        n_checks++; if (nb !== 4)        begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=4", nb); end
        n_checks++; if (sum !== 16'h5555) begin n_fail++; $display("FAIL basic_sum got=%h exp=5555", sum); end
        n_checks++; if (cout !== 1'b0)   begin n_fail++; $display("FAIL basic_cout got=%b exp=0", cout); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        cyc();
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        n_checks++; if (sum !== 16'h5555) begin n_fail++; $display("FAIL basic_sum_hold got=%h exp=5555", sum); end
        n_checks++; if ({add_a, add_b, add_cin} !== 9'h0)
            begin n_fail++; $display("FAIL idle_add got=%h exp=000", {add_a, add_b, add_cin}); end
    endtask

    task automatic test_ripple();
        int lat, nb; logic [3:0] tr;
        do_op(16'hFFFF, 16'h0001, 1'b0, lat, nb, tr);
        n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL ripple_sum got=%h exp=0000", sum); end
        n_checks++; if (cout !== 1'b1)   begin n_fail++; $display("FAIL ripple_cout got=%b exp=1", cout); end
        n_checks++; if (tr !== 4'b1110)  begin n_fail++; $display("FAIL ripple_add_cin got=%b exp=1110", tr); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int lat, nb, n; logic [3:0] tr;
        do_op(16'hFFFF, 16'hFFFF, 1'b1, lat, nb, tr);
        n_checks++; if (sum !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_first_sum got=%h exp=ffff", sum); end
        n_checks++; if (cout !== 1'b1)   begin n_fail++; $display("FAIL b2b_first_cout got=%b exp=1", cout); end
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
        n_checks++; if (sum !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_sum_hold got=%h exp=ffff", sum); end
        n = 1;
        while (done !== 1'b1 && n < 20) begin cyc(); n++; end
        n_checks++; if (n !== 5)         begin n_fail++; $display("FAIL b2b_latency got=%0d exp=5", n); end
        n_checks++; if (sum !== 16'h0003) begin n_fail++; $display("FAIL b2b_second_sum got=%h exp=0003", sum); end
        n_checks++; if (cout !== 1'b0)   begin n_fail++; $display("FAIL b2b_second_cout got=%b exp=0", cout); end
        cyc();
    endtask

    task automatic test_ignore_busy();
        int n, ndone;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        a = 16'h0F0F; b = 16'h0F0F; start = 1'b1;
        cyc();
        start = 1'b0;
        n = 3;
        while (done !== 1'b1 && n < 20) begin cyc(); n++; end
        n_checks++; if (n !== 5)         begin n_fail++; $display("FAIL ignore_latency got=%0d exp=5", n); end
        n_checks++; if (sum !== 16'h3333) begin n_fail++; $display("FAIL ignore_sum got=%h exp=3333", sum); end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0)     begin n_fail++; $display("FAIL ignore_no_second got=%0d exp=0", ndone); end
    endtask

    task automatic test_reset_mid();
        int lat, nb; logic [3:0] tr;
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        cyc();
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
        n_checks++; if (sum !== 16'h0)   begin n_fail++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
        n_checks++; if ({add_a, add_b, add_cin} !== 9'h0)
            begin n_fail++; $display("FAIL midrst_add got=%h exp=000", {add_a, add_b, add_cin}); end
        #2 rst_n = 1'b1;
        cyc();
        do_op(16'h0001, 16'h0002, 1'b0, lat, nb, tr);
        n_checks++; if (sum !== 16'h0003) begin n_fail++; $display("FAIL midrst_after_sum got=%h exp=0003", sum); end
        n_checks++; if (cout !== 1'b0)   begin n_fail++; $display("FAIL midrst_after_cout got=%b exp=0", cout); end
        n_checks++; if (tr !== 4'b0000)  begin n_fail++; $display("FAIL midrst_after_cin got=%b exp=0000", tr); end
        cyc();
    endtask

`ifdef SUMADOR_OVF_EN
    task automatic test_ovf();
        int lat, nb; logic [3:0] tr;
        do_op(16'h7FFF, 16'h0001, 1'b0, lat, nb, tr);
        n_checks++; if ({cout, ovf, sum} !== {1'b0, 1'b1, 16'h8000})
            begin n_fail++; $display("FAIL ovf_pos got=%b%b_%h exp=01_8000", cout, ovf, sum); end
        cyc();
        do_op(16'h8000, 16'h8000, 1'b0, lat, nb, tr);
        n_checks++; if ({cout, ovf, sum} !== {1'b1, 1'b1, 16'h0000})
            begin n_fail++; $display("FAIL ovf_neg got=%b%b_%h exp=11_0000", cout, ovf, sum); end
        cyc();
        do_op(16'h1234, 16'h4321, 1'b0, lat, nb, tr);
        n_checks++; if ({cout, ovf, sum} !== {1'b0, 1'b0, 16'h5555})
            begin n_fail++; $display("FAIL ovf_none got=%b%b_%h exp=00_5555", cout, ovf, sum); end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
`ifdef SUMADOR_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
